ica_iter_scheduler: RTL and testbench
=====================================

Name: ica_iter_scheduler

Overview:
- Top-level iteration sequencer for the one-unit FastICA core.
- Each fixed-point iteration runs in order: fast update round (multiply/mean/subtract pipeline), then normalisation, then convergence check.
- Gates the fast round via go_fast, runs the normaliser handshake, compares |w_new·w_old| against a threshold, and repeats until converged or MAX_ITER is reached.
- Sits between the host start/done interface and the fast controller/normaliser.

Parameters:
- DW, 16, width of dot-product magnitude input (unsigned fixed point).
- FRAC, 14, fractional bits of dot_abs; 1.0 = 1<<FRAC.
- MAX_ITER, 32, maximum iterations before giving up (1..255).
- EPS, 16, convergence tolerance in LSBs; converged when dot_abs >= (1<<FRAC) - EPS.
- TIMEOUT, 200, max cycles allowed waiting on fast_busy/norm_done (used only with the optional feature).

Ports:
- clk_ica  in  1  block clock; same clock as the fast controller.
- go_ica  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run, honoured only in IDLE.
- fast_busy  in  1  busy flag from the fast controller.
- norm_done  in  1  one-cycle pulse from the normaliser; dot_abs is valid in the same cycle.
- dot_abs  in  DW  |w_new·w_old| from the normaliser.
- go_fast  out  1  level; high enables one fast round, low holds the fast controller in reset.
- norm_start  out  1  one-cycle pulse starting normalisation.
- w_load  out  1  one-cycle pulse; copy w_new into w_old.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE until the next start.
- converged  out  1  valid while done is high.
- iter_cnt  out  8  completed iterations.
- err_timeout  out  1  sticky; driven 0 when the feature is absent.

Behaviour:
- Reset (go_ica low, any time, including mid-run): state = IDLE. All outputs 0; iter_cnt = 0.
- IDLE: on start, clear iter_cnt/converged/err_timeout and go to LAUNCH. Other inputs are ignored.
- LAUNCH: go_fast = 1. Wait for fast_busy = 1, then go to RUN. (The fast controller raises busy two cycles after go_fast rises.)
- RUN: go_fast = 1. Wait for fast_busy = 0, then go to NORM. go_fast must fall in the NORM entry cycle, before the fast controller re-enters MUL.
- NORM: go_fast = 0. norm_start pulses for exactly 1 cycle on entry. Wait for norm_done, register dot_abs, then go to CHECK.
- CHECK (1 cycle):
  - iter_cnt <= iter_cnt + 1.
  - hit = (dot_abs_reg >= (1<<FRAC) - EPS), compared at DW+1 bits with no underflow.
  - If hit: converged <= 1, go to DONE.
  - Else if iter_cnt+1 == MAX_ITER: go to DONE with converged = 0.
  - Else go to UPDATE.
- UPDATE (1 cycle): w_load = 1, then go to LAUNCH.
- DONE: done = 1, go_fast = 0. A start pulse restarts exactly as from IDLE; start in any other state is ignored.
- norm_done arriving outside NORM is ignored.
- fast_busy falling in LAUNCH is ignored.
- Latency per iteration = fast round + normaliser latency + 3 cycles (NORM entry, CHECK, UPDATE).
- iter_cnt saturates at MAX_ITER and never wraps.

Optional Feature:
- Macro ICA_ITER_TIMEOUT_EN.
- With it:
  - An 8-bit watchdog counter clears on every state change and increments while in LAUNCH, RUN or NORM.
  - On reaching TIMEOUT: err_timeout <= 1 (sticky until the next start or reset), go_fast <= 0, state -> DONE with converged = 0.
- Without it: no counter, err_timeout tied 0, and waits are unbounded.

Decomposition:
- Shared package ica_pkg holds:
  - state encoding (IDLE, LAUNCH, RUN, NORM, CHECK, UPDATE, DONE; 3-bit);
  - ICA_ONE = 1<<FRAC;
  - default DW/FRAC.
- One natural sub-module: ica_conv_check. It is combinational plus a register: it registers dot_abs and outputs hit. All sequencing stays in the top module.

Test Plan:
- Converge in 3 iterations: fast-controller model, norm_done after 5 cycles, dot_abs = 0x3000, 0x3F00, 0x3FF8 (FRAC=14, EPS=16). Expect:
  - w_load pulses twice;
  - done=1, converged=1, iter_cnt=3;
  - go_fast low in DONE.
- Non-convergence: dot_abs = 0x2000 always, MAX_ITER=4. Expect done with converged=0, iter_cnt=4, and exactly 3 w_load pulses.
- Handshake timing:
  - go_fast falls in the same cycle norm_start pulses;
  - norm_start width is exactly 1;
  - the fast model never reports a second busy period within one iteration.
- Reset mid-RUN: assert go_ica low for 1 cycle during fast_busy=1. Expect all outputs 0 immediately (async) and IDLE afterwards. A later start runs normally from iter_cnt=0.
- Spurious inputs: start pulses during RUN and norm_done pulses during LAUNCH. Expect no state or iter_cnt change.
- ICA_ITER_TIMEOUT_EN, TIMEOUT=20: fast_busy stuck high. Expect:
  - err_timeout=1, done=1, converged=0 about 20 cycles after RUN entry;
  - a subsequent start clears err_timeout.

Source files
------------

// File: rtl/ica_pkg.sv
// Shared definitions for the FastICA iteration scheduler: state encoding,
// fixed-point defaults and the convergence-threshold helper.
package ica_pkg;

  localparam int ICA_DW_DEF   = 16;
  localparam int ICA_FRAC_DEF = 14;
  localparam int ICA_ONE      = 1 << ICA_FRAC_DEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_NORM   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_UPDATE = 3'd5,
    ST_DONE   = 3'd6
  } ica_state_e;

  // Threshold (1.0 - eps) clamped at zero so a large eps cannot underflow.
  function automatic int ica_thresh(input int frac, input int eps);
    return (eps >= (1 << frac)) ? 0 : (1 << frac) - eps;
  endfunction

endpackage

// File: rtl/ica_iter_scheduler_if.sv
// Handshake bundle between the iteration scheduler and its environment
// (host start/done, fast controller, normaliser).
interface ica_iter_scheduler_if #(
  parameter int DW = 16
);
  logic          start;
  logic          fast_busy;
  logic          norm_done;
  logic [DW-1:0] dot_abs;
  logic          go_fast;
  logic          norm_start;
  logic          w_load;
  logic          busy;
  logic          done;
  logic          converged;
  logic [7:0]    iter_cnt;
  logic          err_timeout;

  modport sched (
    input  start, fast_busy, norm_done, dot_abs,
    output go_fast, norm_start, w_load, busy, done, converged, iter_cnt, err_timeout
  );

  modport host (
    output start, fast_busy, norm_done, dot_abs,
    input  go_fast, norm_start, w_load, busy, done, converged, iter_cnt, err_timeout
  );
endinterface

// File: rtl/ica_conv_check.sv
// Convergence comparator: holds the last |w_new.w_old| from the normaliser
// and flags when it is within EPS LSBs of 1.0.
module ica_conv_check
  import ica_pkg::*;
#(
  parameter int DW   = ICA_DW_DEF,
  parameter int FRAC = ICA_FRAC_DEF,
  parameter int EPS  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_capture,
  input  logic [DW-1:0] i_dot_abs,
  output logic          o_hit
);

  localparam logic [DW:0] THRESH = (DW+1)'(ica_thresh(FRAC, EPS));

  logic [DW-1:0] r_dot;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_dot <= '0;
    else if (i_capture) r_dot <= i_dot_abs;
  end

  assign o_hit = ({1'b0, r_dot} >= THRESH);

endmodule

// File: rtl/ica_iter_scheduler.sv
// FastICA iteration sequencer: fast round -> normalise -> convergence check,
// repeated until converged or MAX_ITER. Watchdog under ICA_ITER_TIMEOUT_EN.
module ica_iter_scheduler
  import ica_pkg::*;
#(
  parameter int DW       = ICA_DW_DEF,
  parameter int FRAC     = ICA_FRAC_DEF,
  parameter int MAX_ITER = 32,
  parameter int EPS      = 16
`ifdef ICA_ITER_TIMEOUT_EN
  , parameter int TIMEOUT = 200
`endif
) (
  input  logic              clk_ica,
  input  logic              go_ica,
  ica_iter_scheduler_if.sched bus
);

  ica_state_e r_state, w_state_next;
  logic [7:0] r_iter_cnt;
  logic       r_converged;
  logic       r_norm_start;
  logic       w_hit, w_last, w_start_ok, w_capture;
  logic       w_go_fast, w_w_load, w_busy, w_done, w_err_timeout;

  assign w_start_ok = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_capture  = (r_state == ST_NORM) && bus.norm_done;
  assign w_last     = ({1'b0, r_iter_cnt} + 9'd1) >= 9'(MAX_ITER);

  ica_conv_check #(.DW(DW), .FRAC(FRAC), .EPS(EPS)) u_conv (
    .clk       (clk_ica),
    .rst_n     (go_ica),
    .i_capture (w_capture),
    .i_dot_abs (bus.dot_abs),
    .o_hit     (w_hit)
  );

`ifdef ICA_ITER_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_err_timeout;
  logic       w_wait, w_to;

  assign w_wait = (r_state == ST_LAUNCH) || (r_state == ST_RUN) || (r_state == ST_NORM);
  assign w_to   = w_wait && (r_wdog >= 8'(TIMEOUT));

  always_ff @(posedge clk_ica or negedge go_ica) begin
    if (!go_ica) begin
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_state_next != r_state)   r_wdog <= '0;
      else if (w_wait && !(&r_wdog)) r_wdog <= r_wdog + 8'd1;
      if (w_start_ok) r_err_timeout <= 1'b0;
      else if (w_to)  r_err_timeout <= 1'b1;
    end
  end

  assign w_err_timeout = r_err_timeout;
`else
  assign w_err_timeout = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_go_fast    = 1'b0;
    w_w_load     = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_go_fast = 1'b1;
        if (bus.fast_busy) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_go_fast = 1'b1;
        if (!bus.fast_busy) w_state_next = ST_NORM;
      end
      ST_NORM:   if (bus.norm_done) w_state_next = ST_CHECK;
      ST_CHECK:  w_state_next = (w_hit || w_last) ? ST_DONE : ST_UPDATE;
      ST_UPDATE: begin
        w_w_load     = 1'b1;
        w_state_next = ST_LAUNCH;
      end
      ST_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        if (bus.start) w_state_next = ST_LAUNCH;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
`ifdef ICA_ITER_TIMEOUT_EN
    if (w_to) begin
      w_state_next = ST_DONE;
      w_go_fast    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_ica or negedge go_ica) begin
    if (!go_ica) begin
      r_state      <= ST_IDLE;
      r_iter_cnt   <= '0;
      r_converged  <= 1'b0;
      r_norm_start <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Pulse only on the first NORM cycle, however long the normaliser takes.
      r_norm_start <= (w_state_next == ST_NORM) && (r_state != ST_NORM);
      if (w_start_ok) begin
        r_iter_cnt  <= '0;
        r_converged <= 1'b0;
      end else if (r_state == ST_CHECK) begin
        if (r_iter_cnt != 8'(MAX_ITER)) r_iter_cnt <= r_iter_cnt + 8'd1;
        r_converged <= w_hit;
      end
    end
  end

  assign bus.go_fast     = w_go_fast;
  assign bus.norm_start  = r_norm_start;
  assign bus.w_load      = w_w_load;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.converged   = r_converged;
  assign bus.iter_cnt    = r_iter_cnt;
  assign bus.err_timeout = w_err_timeout;

endmodule

// File: tb/tb_ica_iter_scheduler.sv
// Self-checking bench for ica_iter_scheduler: fast-controller and normaliser
// models, table-driven and randomized runs against an iteration-level reference.
module tb_ica_iter_scheduler;

  localparam int MAXI = 4;
  localparam int FRAC = 14;
  localparam int EPS  = 16;
  localparam int THR  = (1 << FRAC) - EPS;

  logic clk_ica = 1'b0;
  logic go_ica  = 1'b0;
  always #5 clk_ica = ~clk_ica;

  ica_iter_scheduler_if #(.DW(16)) bus ();

  ica_iter_scheduler #(
    .DW(16), .FRAC(FRAC), .MAX_ITER(MAXI), .EPS(EPS)
`ifdef ICA_ITER_TIMEOUT_EN
    , .TIMEOUT(20)
`endif
  ) dut (
    .clk_ica (clk_ica),
    .go_ica  (go_ica),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- environment models ----------------
  logic [15:0] tv_dots [8];
  int   fm_len   = 4;
  bit   fm_stuck = 1'b0;
  int   fm_cnt   = 0;
  int   fm_left  = 0;
  bit   fm_ran   = 1'b0;
  int   fm_extra = 0;
  logic fm_busy  = 1'b0;
  int   nm_lat   = 5;
  int   nm_left  = 0;
  int   nm_idx   = 0;
  logic nm_pulse = 1'b0;
  logic [15:0] nm_dot = '0;
  logic spur_nd  = 1'b0;

  assign bus.fast_busy = fm_busy;
  assign bus.norm_done = nm_pulse | spur_nd;
  assign bus.dot_abs   = spur_nd ? 16'hFFFF : nm_dot;

  // Fast controller: busy two cycles after go_fast rises, for fm_len cycles.
  // A go_fast still high after busy ends would start a second round.
  always @(negedge clk_ica) begin
    if (!bus.go_fast) begin
      fm_cnt = 0; fm_left = 0; fm_ran = 1'b0; fm_busy = 1'b0;
    end else begin
      fm_cnt++;
      if (fm_ran && !fm_busy) fm_extra++;
      else if (fm_cnt == 2) begin
        fm_busy = 1'b1; fm_left = fm_len;
      end else if (fm_busy && !fm_stuck) begin
        fm_left--;
        if (fm_left == 0) begin fm_busy = 1'b0; fm_ran = 1'b1; end
      end
    end
  end

  // Normaliser: norm_done nm_lat cycles after norm_start, next dot value.
  always @(negedge clk_ica) begin
    nm_pulse = 1'b0;
    if (!go_ica) nm_left = 0;
    if (bus.start && !bus.busy) nm_idx = 0;
    if (bus.norm_start) nm_left = nm_lat;
    else if (nm_left > 0) begin
      nm_left--;
      if (nm_left == 0) begin
        nm_pulse = 1'b1;
        nm_dot   = tv_dots[nm_idx];
        nm_idx++;
      end
    end
  end

  // Handshake monitor.
  int   wl_cnt = 0;
  int   ns_cnt = 0;
  logic prev_ns = 1'b0;
  logic prev_gf = 1'b0;
  always @(negedge clk_ica) begin
    if (bus.w_load) wl_cnt++;
    if (bus.norm_start) begin
      ns_cnt++;
      check("norm_start_width", int'(prev_ns), 0);
      check("go_fast_falls_with_norm_start", int'({prev_gf, bus.go_fast}), 2);
    end
    prev_ns = bus.norm_start;
    prev_gf = bus.go_fast;
  end

  // ---------------- reference model ----------------
  function automatic void ref_run(input logic [15:0] d [8], output int iters, output bit conv);
    iters = MAXI;
    conv  = 1'b0;
    for (int i = 0; i < MAXI; i++) begin
      if (int'(d[i]) >= THR) begin
        iters = i + 1; conv = 1'b1;
        return;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_ica); #1; end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!bus.done && cyc < budget) begin tick(); cyc++; end
    check("done_within_budget", int'(bus.done), 1);
  endtask

  task automatic finish_run(input string name, input int wl0, input int ns0,
                            input int exp_iter, input bit exp_conv);
    int cyc;
    wait_done(2000, cyc);
    check({name, "_converged"}, int'(bus.converged), int'(exp_conv));
    check({name, "_iter_cnt"}, int'(bus.iter_cnt), exp_iter);
    check({name, "_w_load_pulses"}, wl_cnt - wl0, exp_iter - 1);
    check({name, "_norm_starts"}, ns_cnt - ns0, exp_iter);
    check({name, "_go_fast_in_done"}, int'(bus.go_fast), 0);
    check({name, "_busy_in_done"}, int'(bus.busy), 0);
    check({name, "_err_timeout"}, int'(bus.err_timeout), 0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] dots [8];
    int          exp_iter;
    bit          exp_conv;
  } vec_t;

  vec_t tbl [5];

  task automatic run_vec(input vec_t v);
    int wl0, ns0;
    tv_dots = v.dots;
    wl0 = wl_cnt; ns0 = ns_cnt;
    pulse_start();
    finish_run(v.name, wl0, ns0, v.exp_iter, v.exp_conv);
  endtask

  initial begin
    int   wl0, ns0, cyc, riters;
    bit   rconv;
    vec_t rv;

    bus.start = 1'b0;
    tbl[0] = '{"conv3",    '{16'h3000, 16'h3F00, 16'h3FF8, 0, 0, 0, 0, 0}, 3, 1'b1};
    tbl[1] = '{"noconv",   '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 0, 0, 0, 0}, 4, 1'b0};
    tbl[2] = '{"edge_thr", '{16'h3FEF, 16'h3FF0, 0, 0, 0, 0, 0, 0}, 2, 1'b1};
    tbl[3] = '{"above_one",'{16'hFFFF, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b1};
    tbl[4] = '{"just_below",'{16'h3FEF, 16'h3FEF, 16'h3FEF, 16'h3FEF, 0, 0, 0, 0}, 4, 1'b0};

    // Reset state.
    tick(2);
    check("rst_go_fast", int'(bus.go_fast), 0);
    check("rst_norm_start", int'(bus.norm_start), 0);
    check("rst_w_load", int'(bus.w_load), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_converged", int'(bus.converged), 0);
    check("rst_iter_cnt", int'(bus.iter_cnt), 0);
    check("rst_err_timeout", int'(bus.err_timeout), 0);
    go_ica = 1'b1;
    tick(2);

    // Table-driven runs.
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Reset in the middle of the second iteration's fast round.
    tv_dots = tbl[1].dots;
    wl0 = wl_cnt;
    pulse_start();
    cyc = 0;
    while (!(wl_cnt > wl0 && bus.fast_busy) && cyc < 500) begin tick(); cyc++; end
    check("midrun_reached_run", int'(bus.fast_busy && bus.go_fast), 1);
    check("midrun_iter_before_reset", int'(bus.iter_cnt), 1);
    go_ica = 1'b0;
    #1;
    check("async_rst_go_fast", int'(bus.go_fast), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_iter_cnt", int'(bus.iter_cnt), 0);
    check("async_rst_done", int'(bus.done), 0);
    tick();
    go_ica = 1'b1;
    tick(3);
    check("after_rst_idle_busy", int'(bus.busy), 0);
    check("after_rst_idle_go_fast", int'(bus.go_fast), 0);
    run_vec(tbl[0]);

    // Spurious norm_done in LAUNCH and start in RUN.
    tv_dots = tbl[0].dots;
    wl0 = wl_cnt; ns0 = ns_cnt;
    pulse_start();
    spur_nd = 1'b1;
    tick();
    spur_nd = 1'b0;
    check("spur_nd_go_fast", int'(bus.go_fast), 1);
    check("spur_nd_norm_start", int'(bus.norm_start), 0);
    check("spur_nd_iter_cnt", int'(bus.iter_cnt), 0);
    tick();
    check("spur_run_reached", int'(bus.fast_busy), 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("spur_start_go_fast", int'(bus.go_fast), 1);
    check("spur_start_busy", int'(bus.busy), 1);
    check("spur_start_iter_cnt", int'(bus.iter_cnt), 0);
    finish_run("spurious", wl0, ns0, 3, 1'b1);

    // Randomized runs against the reference model.
    for (int r = 0; r < 10; r++) begin
      fm_len = $urandom_range(3, 8);
      nm_lat = $urandom_range(1, 6);
      for (int j = 0; j < 8; j++) begin
        if ($urandom_range(0, 1) == 1) rv.dots[j] = 16'(THR - 4 + $urandom_range(0, 8));
        else                           rv.dots[j] = 16'($urandom_range(0, 16'hFFFF));
      end
      ref_run(rv.dots, riters, rconv);
      rv.name     = $sformatf("rand%0d", r);
      rv.exp_iter = riters;
      rv.exp_conv = rconv;
      run_vec(rv);
    end
    fm_len = 4;
    nm_lat = 5;

`ifdef ICA_ITER_TIMEOUT_EN
    // Fast controller hangs with busy high.
    fm_stuck = 1'b1;
    tv_dots  = tbl[0].dots;
    pulse_start();
    cyc = 0;
    while (!bus.fast_busy && cyc < 50) begin tick(); cyc++; end
    wait_done(100, cyc);
    check("to_err_timeout", int'(bus.err_timeout), 1);
    check("to_converged", int'(bus.converged), 0);
    check("to_latency_window", int'(cyc >= 18 && cyc <= 26), 1);
    fm_stuck = 1'b0;
    tick(2);
    wl0 = wl_cnt; ns0 = ns_cnt;
    pulse_start();
    check("to_cleared_by_start", int'(bus.err_timeout), 0);
    finish_run("after_timeout", wl0, ns0, 3, 1'b1);
`endif

    check("no_second_fast_round", fm_extra, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
